uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive engine: the counterpart of the existing TX path. It oversamples the serial line at 16x baud, detects the start bit, samples each data bit at its midpoint and checks the stop bit. Each good byte is emitted as a one-cycle push into the RX FIFO, which the Wishbone RX_DATA register (addr 0x01) reads. Frame format is 8N1, LSB first, with the same divider semantics as the TX side.

Parameters:
DATA_BITS, 8, data bits per frame
DIV_WIDTH, 8, width of freq_divider

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_bit  in  1  serial line input, asynchronous, idles high
freq_divider  in  DIV_WIDTH  oversample tick period minus 1, in clk cycles (12 MHz / 115200 / 16 gives 6)
rx_data  out  DATA_BITS  last received byte; drives RX FIFO data_in
rx_valid  out  1  one-clk pulse when rx_data holds a good byte; drives RX FIFO push
rx_frame_err  out  1  one-clk pulse when a bad stop bit is detected
rx_busy  out  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (reset = 0, asynchronous):
  - rx_data = 0, rx_valid = 0, rx_frame_err = 0, rx_busy = 0
  - synchronizer flops = 1, state = IDLE, all counters = 0
- Input sync: rx_bit passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. Line-to-decision latency is 2 clk.
- Tick generator:
  - Counter runs 0..div_lat, then pulses tick and wraps, so the tick period is div_lat+1 clk.
  - div_lat captures freq_divider on start detection and is held for the whole frame. A divider change mid-frame takes effect on the next frame.
  - The counter is cleared on start detection, so tick phase aligns to the falling edge.
- Oversample counter: os_cnt, 4 bits, increments on tick and wraps 15 to 0.
- States:
  - IDLE: when rx_s = 0, clear os_cnt and the tick counter, go to START, set rx_busy = 1.
  - START: on the tick where os_cnt = 7 (mid start bit):
    - rx_s = 1: false start/glitch. Go to IDLE, rx_busy = 0, no outputs.
    - otherwise: clear os_cnt, bit_idx = 0, go to DATA.
  - DATA: on the tick where os_cnt = 15, shift rx_s into the shift register MSB (LSB-first line order).
    - bit_idx = DATA_BITS-1: go to STOP (or PARITY when enabled).
    - otherwise: bit_idx++.
  - STOP: on the tick where os_cnt = 15, sample rx_s.
    - 1: next clk rx_data = shift register, rx_valid = 1 for exactly one clk, then IDLE.
    - 0: rx_frame_err = 1 for one clk, rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s = 1 (break or held-low line), then IDLE. No start detection while in this state.
- rx_valid and rx_frame_err are never high together. rx_data holds its value until the next rx_valid.
- Back-to-back frames: a start bit immediately following the stop sample is detected from IDLE with no lost byte. The stop bit is sampled mid-bit, leaving half a bit of margin.
- FIFO full is not observed. The push is issued regardless, and drop policy is the FIFO's.
- Reset mid-frame aborts immediately, with no partial rx_valid.

Optional Feature:
UART_RX_PARITY_EN:
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at os_cnt = 15.
  - Adds input rx_parity_odd (0 = even, 1 = odd) and output rx_parity_err, a one-clk pulse coincident with the STOP decision.
  - On parity mismatch with a good stop bit: rx_parity_err = 1 and rx_valid = 0, byte dropped.
  - A bad stop bit takes precedence and reports rx_frame_err only.
- Undefined: 8N1 only; the port and state are absent.

Decomposition:
- Shared include uart_defs.vh holds:
  - register addresses TX_DATA_ADDR, RX_DATA_ADDR, FREQ_DIV_ADDR
  - HIGH/LOW
  - RX state encodings IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  - OVERSAMPLE = 16 and MID_SAMPLE = 7
- One sub-module, uart_baud_tick: divider counter with sync clear and load. It is reusable by the TX path.

Test Plan:
All frames at freq_divider = 6: tick = 7 clk, bit = 112 clk.
- 0x55 frame, stop = 1 -> exactly one rx_valid; rx_data = 0x55; rx_frame_err never high; rx_busy low within 2 clk after the valid.
- Back-to-back 0x00, 0xFF, 0xA5 with no idle gap -> three rx_valid pulses, in order, with correct data.
- Line low for 21 clk, then high -> no rx_valid, no rx_frame_err; FSM back in IDLE; a following 0x3C is received correctly.
- 0xA3 with stop bit = 0, line then held low for 500 clk -> one rx_frame_err pulse and no rx_valid; rx_busy stays high until the line rises; the next 0x12 is received.
- reset asserted for 1 clk mid-DATA of 0x81 -> all outputs 0 immediately; no valid for the aborted frame; the next 0x7E is received.
- With UART_RX_PARITY_EN, even parity, 0x07 sent with parity bit 0 -> rx_parity_err pulse and no rx_valid; with parity bit 1 -> rx_valid with rx_data = 0x07.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: register map, line levels, RX state encoding and
// oversampling constants. Used by uart_rx (optional parity via UART_RX_PARITY_EN).
package uart_rx_pkg;

  localparam logic [7:0] TX_DATA_ADDR  = 8'h00;
  localparam logic [7:0] RX_DATA_ADDR  = 8'h01;
  localparam logic [7:0] FREQ_DIV_ADDR = 8'h02;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_SAMPLE = 4'd7;
  localparam logic [3:0] OS_LAST    = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..latched divider and pulses o_tick on wrap.
// i_clr realigns the phase, i_load latches a new divider; shared with the TX path.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div_lat;

  assign o_tick = (r_cnt == r_div_lat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_div_lat <= '0;
    end else begin
      if (i_load) r_div_lat <= i_div;
      if (i_clr || o_tick) r_cnt <= '0;
      else                 r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive engine, 16x oversampled, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add a parity bit (rx_parity_odd / rx_parity_err).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_bit,
  input  logic [DIV_WIDTH-1:0] freq_divider,
`ifdef UART_RX_PARITY_EN
  input  logic                 rx_parity_odd,
  output logic                 rx_parity_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_rx_s;
  rx_state_t            r_state;
  logic [3:0]           r_os_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_busy;
  logic                 w_start;
  logic                 w_tick;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  function automatic logic f_parity_bad(input logic [DATA_BITS-1:0] d,
                                        input logic p, input logic odd);
    return (^d) ^ p ^ odd;
  endfunction

  assign rx_parity_err = r_parity_err;
`endif

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_busy      = r_busy;

  assign w_start = (r_state == IDLE) && (r_rx_s == LOW);

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_start),
    .i_load (w_start),
    .i_div  (freq_divider),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= HIGH;
      r_rx_s  <= HIGH;
    end else begin
      r_sync1 <= rx_bit;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_os_cnt    <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (w_tick) r_os_cnt <= r_os_cnt + 4'd1;
      case (r_state)
        IDLE: begin
          if (r_rx_s == LOW) begin
            r_os_cnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= START;
          end
        end
        START: begin
          // Mid start bit: a high line here was only a glitch.
          if (w_tick && r_os_cnt == MID_SAMPLE) begin
            if (r_rx_s == HIGH) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_os_cnt  <= '0;
              r_bit_idx <= '0;
              r_state   <= DATA;
            end
          end
        end
        DATA: begin
          if (w_tick && r_os_cnt == OS_LAST) begin
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick && r_os_cnt == OS_LAST) begin
            r_par_bit <= r_rx_s;
            r_state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick && r_os_cnt == OS_LAST) begin
            if (r_rx_s == HIGH) begin
`ifdef UART_RX_PARITY_EN
              if (f_parity_bad(r_shift, r_par_bit, rx_parity_odd)) begin
                r_parity_err <= 1'b1;
              end else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
`else
              r_data  <= r_shift;
              r_valid <= 1'b1;
`endif
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (r_rx_s == HIGH) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: randomized frames, queue-based scoreboard,
// independent monitor. Exercises parity when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_bit;
  logic [7:0] freq_divider;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;
  logic       par_odd;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         n_cmp = 0;
  int         n_err = 0;

  uart_rx #(.DATA_BITS(8), .DIV_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_bit       (rx_bit),
    .freq_divider (freq_divider),
`ifdef UART_RX_PARITY_EN
    .rx_parity_odd(par_odd),
    .rx_parity_err(rx_parity_err),
`endif
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx_bit = v;
    wait_clk(n);
  endtask

  // Model: one frame yields exactly one outcome, decided from the frame content.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    int   bt;
    exp_t e;
    bt     = (int'(freq_divider) + 1) * 16;
    e.data = last_good;
    if (!stop_v)       e.kind = K_FERR;
    else if (par_flip) e.kind = K_PERR;
    else begin
      e.kind    = K_VALID;
      e.data    = d;
      last_good = d;
    end
    exp_q.push_back(e);
    drive_bit(1'b0, bt);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_odd ^ par_flip, bt);
`endif
    drive_bit(stop_v, bt);
  endtask

  initial begin : monitor
    int   kind;
    exp_t e;
    forever begin
      @(negedge clk);
      kind = -1;
      if (rx_valid)          kind = K_VALID;
      else if (rx_frame_err) kind = K_FERR;
`ifdef UART_RX_PARITY_EN
      else if (rx_parity_err) kind = K_PERR;
`endif
      if (kind >= 0) begin
        n_cmp++;
        if (rx_valid && rx_frame_err) begin
          n_err++;
          $display("FAIL excl: rx_valid and rx_frame_err both high at %0t", $time);
        end else if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: kind %0d data %0h, expected none at %0t",
                   kind, rx_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != kind || rx_data !== e.data) begin
            n_err++;
            $display("FAIL event: kind %0d data %0h, expected kind %0d data %0h at %0t",
                     kind, rx_data, e.kind, e.data, $time);
          end
        end
        if (kind == K_VALID) begin
          for (int i = 0; i < 2 && rx_busy; i++) @(negedge clk);
          check("busy_after_valid", {31'd0, rx_busy}, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] d;
    logic       sb;
    logic       pf;
    reset        = 1'b0;
    rx_bit       = 1'b1;
    freq_divider = 8'd6;
    par_odd      = 1'b0;
    last_good    = 8'h00;
    wait_clk(4);
    check("rst_data",  {24'd0, rx_data}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr",  {31'd0, rx_frame_err}, 32'd0);
    check("rst_busy",  {31'd0, rx_busy}, 32'd0);
    reset = 1'b1;
    wait_clk(40);

    send_frame(8'h55, 1'b1, 1'b0);
    wait_clk(60);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, 1'b0);
    wait_clk(60);

    drive_bit(1'b0, 21);
    drive_bit(1'b1, 112);
    check("glitch_idle_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_clk(60);

    send_frame(8'hA3, 1'b0, 1'b0);
    wait_clk(250);
    check("ferr_busy_held", {31'd0, rx_busy}, 32'd1);
    wait_clk(250);
    drive_bit(1'b1, 6);
    check("ferr_busy_release", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h12, 1'b1, 1'b0);
    wait_clk(60);

    // 0x81 LSB first: 1,0,0,... ; abort partway through bit 3
    drive_bit(1'b0, 112);
    drive_bit(1'b1, 112);
    drive_bit(1'b0, 112);
    drive_bit(1'b0, 112);
    drive_bit(1'b0, 50);
    check("pre_reset_busy", {31'd0, rx_busy}, 32'd1);
    reset  = 1'b0;
    rx_bit = 1'b1;
    #1;
    check("mid_rst_data",  {24'd0, rx_data}, 32'd0);
    check("mid_rst_busy",  {31'd0, rx_busy}, 32'd0);
    check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("mid_rst_ferr",  {31'd0, rx_frame_err}, 32'd0);
    last_good = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    wait_clk(300);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_clk(60);

    // Divider change mid-frame only affects the following frame
    fork
      send_frame(8'hC6, 1'b1, 1'b0);
      begin
        wait_clk(300);
        freq_divider = 8'd3;
      end
    join
    send_frame(8'h9B, 1'b1, 1'b0);
    freq_divider = 8'd6;
    wait_clk(60);

    for (int i = 0; i < 14; i++) begin
      if (i >= 8) freq_divider = 8'($urandom_range(2, 9));
      d  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      pf = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_odd = 1'($urandom_range(0, 1));
      pf      = ($urandom_range(0, 4) == 0);
`endif
      send_frame(d, sb, pf);
      if (!sb) begin
        wait_clk($urandom_range(0, 300));
        drive_bit(1'b1, 6);
      end
      wait_clk($urandom_range(0, 150));
    end
    freq_divider = 8'd6;
    par_odd      = 1'b0;
    wait_clk(60);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clk(30);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clk(30);
    par_odd = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_clk(200);
    drive_bit(1'b1, 6);
    par_odd = 1'b0;
`endif

    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
